// File: rtl/store_rmw_if.sv
`default_nettype none
// ============================================================================
// Module      : store_rmw_if
// Description : Bus bundle between the control unit / data memory (master)
//               and the store read-modify-write unit (slave).
//   START     request pulse from the control unit
//   ADDR      byte address of the store
//   B         store data (low byte / half / word used)
//   CT        store type: 0 word, 1 halfword, 2 byte, 3 illegal
//   MR        memory read data
//   MEM_ADDR  word-aligned memory address
//   MEM_RD    memory read strobe
//   MEM_WR    memory write strobe
//   WDATA     merged write data
//   BUSY      unit is not idle
//   DONE      one-cycle completion pulse
//   ERR       one-cycle error pulse, coincident with DONE
// Revision    : 1.0 - initial release
// ============================================================================
interface store_rmw_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              START;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] B;
  logic [1:0]        CT;
  logic [DATA_W-1:0] MR;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_RD;
  logic              MEM_WR;
  logic [DATA_W-1:0] WDATA;
  logic              BUSY;
  logic              DONE;
  logic              ERR;

  modport master (
    output START, ADDR, B, CT, MR,
    input  MEM_ADDR, MEM_RD, MEM_WR, WDATA, BUSY, DONE, ERR
  );

  modport slave (
    input  START, ADDR, B, CT, MR,
    output MEM_ADDR, MEM_RD, MEM_WR, WDATA, BUSY, DONE, ERR
  );
endinterface
`default_nettype wire

// File: rtl/store_rmw_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_rmw_unit
// Description : Sequential word / halfword / byte store engine. Word stores
//               write straight through; sub-word stores read the containing
//               word, merge the selected lane(s) little-endian and write the
//               word back. BUSY/DONE let the control FSM stall on it.
// Ports       :
//   clk       clock, rising edge
//   reset     asynchronous active-low reset
//   bus       store_rmw_if.slave (request, memory and status signals)
// Parameters  : DATA_W (multiple of 16), ADDR_W, MEM_LAT (1..7)
// Revision    : 1.0 - initial release
// ============================================================================
module store_rmw_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  store_rmw_if.slave  bus
);

  localparam int LANES = DATA_W / 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [1:0] CT_WORD = 2'd0;
  localparam logic [1:0] CT_HALF = 2'd1;
  localparam logic [1:0] CT_BYTE = 2'd2;
  localparam logic [1:0] CT_ILL  = 2'd3;

  // Counter value of the final WAIT cycle.
  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [15:0]       bhw_q,   bhw_d;   // only the low half of B feeds a merge
  logic [1:0]        ct_q,    ct_d;
  logic              err_q,   err_d;
  logic [2:0]        cnt_q,   cnt_d;
  logic [DATA_W-1:0] wdat_q,  wdat_d;  // word to be written in WR

  logic              req_err;
  logic [DATA_W-1:0] merge_word;

  // Illegal type or misaligned address, judged on the live request.
  assign req_err = (bus.CT == CT_ILL) ||
                   ((bus.CT == CT_WORD) && (bus.ADDR[1:0] != 2'b00)) ||
                   ((bus.CT == CT_HALF) && bus.ADDR[0]);

  // Little-endian lane merge of the latched store data into MR.
  always_comb begin
    merge_word = bus.MR;
    for (int i = 0; i < LANES; i++) begin
      if ((ct_q == CT_BYTE) && (i == int'(addr_q[1:0]))) begin
        merge_word[8*i +: 8] = bhw_q[7:0];
      end else if ((ct_q == CT_HALF) && ((i / 2) == int'(addr_q[1]))) begin
        merge_word[8*i +: 8] = ((i % 2) == 0) ? bhw_q[7:0] : bhw_q[15:8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bhw_d   = bhw_q;
    ct_d    = ct_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    wdat_d  = wdat_q;
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          addr_d = bus.ADDR;
          bhw_d  = bus.B[15:0];
          ct_d   = bus.CT;
          err_d  = req_err;
          // Word stores write B unchanged; sub-word paths overwrite this
          // with the merged word at the end of WAIT.
          wdat_d = bus.B;
          if (req_err) begin
            state_d = S_FIN;
          end else if (bus.CT == CT_WORD) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        cnt_d   = 3'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          wdat_d  = merge_word;
          state_d = S_WR;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_WR: begin
        state_d = S_FIN;
      end
      S_FIN: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      bhw_q   <= '0;
      ct_q    <= CT_WORD;
      err_q   <= 1'b0;
      cnt_q   <= 3'd0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bhw_q   <= bhw_d;
      ct_q    <= ct_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      wdat_q  <= wdat_d;
    end
  end

  // All outputs decode from registered state, so START never reaches them
  // combinationally.
  assign bus.MEM_RD   = (state_q == S_RD);
  assign bus.MEM_WR   = (state_q == S_WR);
  assign bus.BUSY     = (state_q != S_IDLE);
  assign bus.DONE     = (state_q == S_FIN);
  assign bus.ERR      = (state_q == S_FIN) && err_q;
  assign bus.MEM_ADDR = (state_q == S_IDLE) ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.WDATA    = (state_q == S_WR) ? wdat_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_store_rmw_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_rmw_unit
// Description : Scoreboard bench for store_rmw_unit. Two instances are built,
//               MEM_LAT = 1 (dut0) and MEM_LAT = 3 (dut1). Stimulus pushes
//               the expected MEM_RD / MEM_WR / DONE events with their cycle
//               numbers; a negedge monitor pops and compares them whenever a
//               DUT raises one of those strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_rmw_unit;

  localparam int K_RD   = 0;
  localparam int K_WR   = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
  } exp_t;

  logic clk;
  logic rst1;
  logic rst3;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  store_rmw_if #(.DATA_W(32), .ADDR_W(32)) if1 ();
  store_rmw_if #(.DATA_W(32), .ADDR_W(32)) if3 ();

  store_rmw_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) u_lat1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (if1)
  );

  store_rmw_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(3)) u_lat3 (
    .clk   (clk),
    .reset (rst3),
    .bus   (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  function automatic string kname(int k);
    case (k)
      K_RD:    return "MEM_RD";
      K_WR:    return "MEM_WR";
      default: return "DONE";
    endcase
  endfunction

  function automatic void push(int d, int kind, int c, logic [31:0] a, logic [31:0] w, logic e);
    exp_t x;
    x.kind = kind; x.cyc = c; x.addr = a; x.wdata = w; x.err = e;
    if (d == 0) q0.push_back(x); else q1.push_back(x);
  endfunction

  function automatic void flush(int d);
    if (d == 0) q0.delete(); else q1.delete();
  endfunction

  function automatic void take(int d, int kind, logic [31:0] ma, logic [31:0] wd, logic er);
    exp_t x;
    bit   got;
    got = 1'b0;
    if (d == 0 && q0.size() > 0) begin x = q0.pop_front(); got = 1'b1; end
    else if (d == 1 && q1.size() > 0) begin x = q1.pop_front(); got = 1'b1; end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL dut%0d unexpected_event: got %s at cycle %0d, required none", d, kname(kind), cyc);
      return;
    end
    checks++;
    if (x.kind != kind || x.cyc != cyc) begin
      errors++;
      $display("FAIL dut%0d event_timing: got %s at cycle %0d, required %s at cycle %0d",
               d, kname(kind), cyc, kname(x.kind), x.cyc);
    end
    if (kind != K_DONE) begin
      checks++;
      if (ma !== x.addr) begin
        errors++;
        $display("FAIL dut%0d mem_addr on %s: got %h, required %h", d, kname(kind), ma, x.addr);
      end
    end
    if (kind == K_WR) begin
      checks++;
      if (wd !== x.wdata) begin
        errors++;
        $display("FAIL dut%0d wdata: got %h, required %h", d, wd, x.wdata);
      end
    end
    if (kind == K_DONE) begin
      checks++;
      if (er !== x.err) begin
        errors++;
        $display("FAIL dut%0d err_flag: got %b, required %b", d, er, x.err);
      end
    end
  endfunction

  function automatic void mon(int d, logic rd, logic wr, logic dn, logic er, logic bsy,
                              logic [31:0] ma, logic [31:0] wd);
    checks++;
    if (rd === 1'b1 && wr === 1'b1) begin
      errors++;
      $display("FAIL dut%0d rd_wr_overlap cycle %0d: MEM_RD=%b MEM_WR=%b, required not both 1", d, cyc, rd, wr);
    end
    checks++;
    if (wr !== 1'b1 && wd !== 32'h0) begin
      errors++;
      $display("FAIL dut%0d wdata_idle cycle %0d: got %h, required 0", d, cyc, wd);
    end
    checks++;
    if (er === 1'b1 && dn !== 1'b1) begin
      errors++;
      $display("FAIL dut%0d err_without_done cycle %0d: DONE=%b, required 1", d, cyc, dn);
    end
    if (bsy !== 1'b1) begin
      checks++;
      if ({rd, wr, dn, er} !== 4'b0000 || ma !== 32'h0) begin
        errors++;
        $display("FAIL dut%0d idle_outputs cycle %0d: rd/wr/done/err=%b%b%b%b addr=%h, required all 0",
                 d, cyc, rd, wr, dn, er, ma);
      end
    end
    if (rd === 1'b1) take(d, K_RD, ma, wd, er);
    if (wr === 1'b1) take(d, K_WR, ma, wd, er);
    if (dn === 1'b1) take(d, K_DONE, ma, wd, er);
  endfunction

  always @(negedge clk) begin
    mon(0, if1.MEM_RD, if1.MEM_WR, if1.DONE, if1.ERR, if1.BUSY, if1.MEM_ADDR, if1.WDATA);
    mon(1, if3.MEM_RD, if3.MEM_WR, if3.DONE, if3.ERR, if3.BUSY, if3.MEM_ADDR, if3.WDATA);
  end

  task automatic drive(input int d, input logic st, input logic [31:0] a,
                       input logic [31:0] bv, input logic [1:0] ct);
    if (d == 0) begin
      if1.START = st; if1.ADDR = a; if1.B = bv; if1.CT = ct;
    end else begin
      if3.START = st; if3.ADDR = a; if3.B = bv; if3.CT = ct;
    end
  endtask

  task automatic drive_mr(input int d, input logic [31:0] v);
    if (d == 0) if1.MR = v; else if3.MR = v;
  endtask

  task automatic check_reset_state(input int d);
    logic [70:0] v;
    if (d == 0) v = {if1.BUSY, if1.DONE, if1.ERR, if1.MEM_RD, if1.MEM_WR, if1.MEM_ADDR, if1.WDATA};
    else        v = {if3.BUSY, if3.DONE, if3.ERR, if3.MEM_RD, if3.MEM_WR, if3.MEM_ADDR, if3.WDATA};
    checks++;
    if (v !== 71'h0) begin
      errors++;
      $display("FAIL dut%0d reset_state: outputs %h, required 0", d, v);
    end
  endtask

  // One complete request; MR carries mrv only in the final WAIT cycle.
  task automatic run_store(input int d, input logic [31:0] a, input logic [31:0] bv,
                           input logic [1:0] ct, input logic [31:0] mrv,
                           input logic [31:0] expw, input logic experr);
    int          lat;
    int          t0;
    bit          seen;
    logic [31:0] al;
    lat = (d == 0) ? 1 : 3;
    al  = {a[31:2], 2'b00};
    @(negedge clk);
    t0 = cyc;
    drive(d, 1'b1, a, bv, ct);
    drive_mr(d, 32'h0BAD_F00D);
    if (experr) begin
      push(d, K_DONE, t0 + 1, 32'h0, 32'h0, 1'b1);
    end else if (ct == 2'd0) begin
      push(d, K_WR,   t0 + 1, al, expw, 1'b0);
      push(d, K_DONE, t0 + 2, 32'h0, 32'h0, 1'b0);
    end else begin
      push(d, K_RD,   t0 + 1, al, 32'h0, 1'b0);
      push(d, K_WR,   t0 + 2 + lat, al, expw, 1'b0);
      push(d, K_DONE, t0 + 3 + lat, 32'h0, 32'h0, 1'b0);
    end
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      // Scrambled inputs after the request must not disturb the latched one.
      if (k == 1) drive(d, 1'b0, ~a, ~bv, 2'd3);
      drive_mr(d, (cyc == t0 + 1 + lat) ? mrv : (32'h0BAD_F00D ^ 32'(k)));
      seen = (d == 0) ? if1.DONE : if3.DONE;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL dut%0d timeout addr %h: DONE not seen within 20 cycles, required DONE", d, a);
      flush(d);
    end
    @(negedge clk);
  endtask

  initial begin
    int t0;
    rst1 = 1'b0;
    rst3 = 1'b0;
    drive(0, 1'b0, 32'h0, 32'h0, 2'd0);
    drive(1, 1'b0, 32'h0, 32'h0, 2'd0);
    drive_mr(0, 32'h0);
    drive_mr(1, 32'h0);
    repeat (3) @(negedge clk);
    check_reset_state(0);
    check_reset_state(1);
    rst1 = 1'b1;
    rst3 = 1'b1;
    repeat (2) @(negedge clk);

    // MEM_LAT = 1 instance
    run_store(0, 32'h0000_0010, 32'hDEAD_BEEF, 2'd0, 32'h0,         32'hDEAD_BEEF, 1'b0);
    run_store(0, 32'h0000_0021, 32'h0000_0008, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_08FF, 1'b0);
    run_store(0, 32'h0000_0042, 32'hAAAA_1234, 2'd1, 32'hFFFF_FFFF, 32'h1234_FFFF, 1'b0);
    run_store(0, 32'h0000_0040, 32'hAAAA_1234, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_1234, 1'b0);
    run_store(0, 32'h0000_0043, 32'h0000_1111, 2'd1, 32'h0,         32'h0,         1'b1);
    run_store(0, 32'h0000_0002, 32'h2222_2222, 2'd0, 32'h0,         32'h0,         1'b1);
    run_store(0, 32'h0000_0080, 32'h3333_3333, 2'd3, 32'h0,         32'h0,         1'b1);
    run_store(0, 32'h0000_0060, 32'h0000_0077, 2'd2, 32'h1122_3344, 32'h1122_3377, 1'b0);

    // MEM_LAT = 3 instance
    run_store(1, 32'h0000_0103, 32'h0000_005A, 2'd2, 32'h1122_3344, 32'h5A22_3344, 1'b0);
    run_store(1, 32'h0000_0102, 32'h0000_BEEF, 2'd1, 32'h1122_3344, 32'hBEEF_3344, 1'b0);
    run_store(1, 32'h0000_0200, 32'hCAFE_F00D, 2'd0, 32'h0,         32'hCAFE_F00D, 1'b0);

    // Reset dropped during WAIT aborts the store with no write.
    @(negedge clk);
    t0 = cyc;
    drive(1, 1'b1, 32'h0000_0107, 32'h0000_0001, 2'd2);
    push(1, K_RD, t0 + 1, 32'h0000_0104, 32'h0, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, 32'h0, 32'h0, 2'd0);
    @(negedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    checks++;
    if (if3.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL dut1 busy_after_reset: got %b, required 0", if3.BUSY);
    end
    repeat (2) @(negedge clk);
    rst3 = 1'b1;
    repeat (8) @(negedge clk);
    run_store(1, 32'h0000_0301, 32'h0000_00C3, 2'd2, 32'hA0B0_C0D0, 32'hA0B0_C3D0, 1'b0);

    // START pulses while busy and in FIN are ignored: exactly one DONE.
    @(negedge clk);
    t0 = cyc;
    drive(0, 1'b1, 32'h0000_0031, 32'h0000_0055, 2'd2);
    drive_mr(0, 32'h0BAD_F00D);
    push(0, K_RD,   t0 + 1, 32'h0000_0030, 32'h0, 1'b0);
    push(0, K_WR,   t0 + 3, 32'h0000_0030, 32'hFFFF_55FF, 1'b0);
    push(0, K_DONE, t0 + 4, 32'h0, 32'h0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      case (k)
        2:       drive(0, 1'b1, 32'h0000_0050, 32'h1234_5678, 2'd0);
        4:       drive(0, 1'b1, 32'h0000_0054, 32'h8765_4321, 2'd0);
        default: drive(0, 1'b0, 32'h0000_0050, 32'h1234_5678, 2'd0);
      endcase
      drive_mr(0, (k == 2) ? 32'hFFFF_FFFF : 32'h0BAD_F00D);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL dut0 pending_events: got %0d outstanding, required 0", q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL dut1 pending_events: got %0d outstanding, required 0", q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Sequential, parametrised successor to the combinational store mask.
- Performs complete word, halfword and byte stores to a word-addressed data memory.
- For sub-word stores it runs a read-modify-write: read the containing word, merge the selected lane(s) from B at the byte offset given by ADDR, then write the word back.
- Sits between the control unit and data memory; BUSY/DONE let the control FSM stall on it.

Parameters:
- DATA_W, 32: data word width; must be a multiple of 16 (lanes = DATA_W/8).
- ADDR_W, 32: byte address width.
- MEM_LAT, 1: cycles from the MEM_RD cycle to MR valid; legal range 1..7.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- START  in  1  request pulse; sampled only in IDLE.
- ADDR  in  ADDR_W  byte address of the store.
- B  in  DATA_W  store data; the low byte/half/word is used.
- CT  in  2  store type: 0 = word, 1 = halfword, 2 = byte, 3 = illegal.
- MR  in  DATA_W  memory read data.
- MEM_ADDR  out  ADDR_W  word-aligned address: {ADDR_q[ADDR_W-1:2], 2'b00}.
- MEM_RD  out  1  memory read strobe.
- MEM_WR  out  1  memory write strobe.
- WDATA  out  DATA_W  merged write data.
- BUSY  out  1  high in every state other than IDLE.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  one-cycle pulse, coincident with DONE, on a misaligned or illegal request.

Behaviour:
- Reset (reset low, asynchronous): state = IDLE, wait counter = 0, all outputs 0.
- Reset asserted mid-operation aborts the operation; no MEM_WR is issued afterwards.
- IDLE + START:
  - Latch ADDR, B and CT into ADDR_q, B_q, CT_q.
  - Later changes on ADDR/B/CT are ignored until return to IDLE.
  - START while BUSY is ignored; it is not queued.
- Error check at START:
  - CT = 3 is illegal.
  - CT = 0 with ADDR[1:0] != 0 is misaligned.
  - CT = 1 with ADDR[0] = 1 is misaligned.
  - On error: go to FIN with ERR; no MEM_RD and no MEM_WR.
- Word store (CT = 0): IDLE -> WR -> FIN.
  - WDATA = B_q.
  - MEM_WR is high in cycle 1 after the START edge.
  - DONE is high in cycle 2.
- Sub-word store (CT = 1 or 2): IDLE -> RD -> WAIT -> WR -> FIN.
  - RD: MEM_RD = 1 for exactly one cycle; counter cleared.
  - WAIT: stay MEM_LAT cycles; sample MR into the merge register on the edge that ends the last WAIT cycle.
  - WR: MEM_WR = 1 for one cycle at cycle 2+MEM_LAT. FIN: DONE at cycle 3+MEM_LAT.
- Merge rule (little-endian, k = ADDR_q[1:0]):
  - Byte: bits [8k+7:8k] = B_q[7:0]; all other bits come from MR.
  - Halfword: bits [16j+15:16j] = B_q[15:0], with j = ADDR_q[1]; other bits come from MR.
- FIN: DONE = 1 for one cycle (ERR too if flagged), then IDLE. A START in FIN is ignored.
- Output timing:
  - MEM_ADDR is valid and stable from RD/WR entry until FIN, and 0 in IDLE.
  - WDATA is valid only while MEM_WR = 1, otherwise 0.
  - MEM_RD and MEM_WR are never high in the same cycle.
  - All outputs are registered or decoded from state only; no combinational path from START.

Test Plan:
- Word store: ADDR = 0x10, B = 0xDEADBEEF, CT = 0 -> MEM_WR in cycle 1, MEM_ADDR = 0x10, WDATA = 0xDEADBEEF, DONE in cycle 2, MEM_RD never high.
- Byte store, MEM_LAT = 1: ADDR = 0x21, B = 0x00000008, CT = 2, MR = 0xFFFFFFFF -> MEM_RD in cycle 1; MEM_WR in cycle 3 with MEM_ADDR = 0x20, WDATA = 0xFFFF08FF; DONE in cycle 4.
- Halfword store: ADDR = 0x42, B = 0xAAAA1234, CT = 1, MR = 0xFFFFFFFF -> WDATA = 0x1234FFFF. Repeat at ADDR = 0x40 -> WDATA = 0xFFFF1234.
- Errors: CT = 1 at ADDR = 0x43, CT = 0 at ADDR = 0x02, and CT = 3 -> each gives DONE = ERR = 1 in cycle 1, with MEM_RD = MEM_WR = 0 throughout.
- MEM_LAT = 3 build: byte store at offset 3, B = 0x5A, MR = 0x11223344 presented only in the last WAIT cycle -> MEM_WR in cycle 5 with WDATA = 0x5A223344; DONE in cycle 6.
- Reset and START handling:
  - Drop reset during WAIT -> BUSY = 0 immediately; no MEM_WR follows; a new START afterwards completes normally.
  - START pulsed while BUSY -> exactly one DONE.
